// File: rtl/seq_mul16_if.sv
// Operand/result handshake bundle for the iterative multiplier.
// master = operand source and result consumer, slave = the multiplier.
interface seq_mul16_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/seq_mul16.sv
// Iterative shift-and-add multiplier: one multiplier bit per RUN cycle.
// The result is the low WIDTH bits of a*b; valid/ready handshake on both sides.
module seq_mul16 #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input logic        clk,
    input logic        reset,
    seq_mul16_if.slave bus
);
    localparam int unsigned   CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] mplier_shr;

    // Carry-out is dropped on purpose: only the low WIDTH product bits are kept.
    assign sum        = acc_q + mcand_q;
    assign mplier_shr = mplier_q >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = (EARLY_EXIT && (bus.b == '0)) ? StDone : StRun;
                end
            end
            StRun: begin
                if (mplier_q[0]) begin
                    acc_d = sum;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                count_d  = count_q + 1'b1;
                if ((count_q == LastCount) || (EARLY_EXIT && (mplier_shr == '0))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // acc is left untouched so out keeps showing the last product.
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out       = acc_q;

endmodule

// File: tb/tb_seq_mul16.sv
// Directed and random scoreboard bench for seq_mul16, covering both the
// full-latency build and the EARLY_EXIT build side by side.
module tb_seq_mul16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid0 = 1'b0;
    logic        in_valid1 = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    int total = 0;
    int bad = 0;

    logic [15:0] sb_q[$];
    logic [15:0] ee_q[$];

    always #5 clk = ~clk;

    seq_mul16_if #(.WIDTH(16)) bus0 ();
    seq_mul16_if #(.WIDTH(16)) bus1 ();

    assign bus0.in_valid  = in_valid0;
    assign bus0.a         = a;
    assign bus0.b         = b;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid1;
    assign bus1.a         = a;
    assign bus1.b         = b;
    assign bus1.out_ready = out_ready;

    seq_mul16 #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    seq_mul16 #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_mul(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] full;
        full = 32'(x) * 32'(y);
        return full[15:0];
    endfunction

    function automatic logic dut_ov(input bit ee);
        return ee ? bus1.out_valid : bus0.out_valid;
    endfunction

    task automatic sb_check(input bit ee, input string tag, input logic [15:0] obs);
        int          sz;
        logic [15:0] e;
        sz = ee ? ee_q.size() : sb_q.size();
        check({tag, "_sb_nonempty"}, 32'(sz != 0), 32'd1);
        if (sz != 0) begin
            e = ee ? ee_q.pop_front() : sb_q.pop_front();
            check(tag, 32'(obs), 32'(e));
        end
    endtask

    // One complete transaction with out_ready held high; operands are scrambled
    // right after the accept edge so late operand changes would show up.
    task automatic op(input bit ee, input logic [15:0] x, input logic [15:0] y,
                      input int exp_lat, input string tag);
        int lat;
        a = x;
        b = y;
        out_ready = 1'b1;
        if (ee) begin
            ee_q.push_back(model_mul(x, y));
            in_valid1 = 1'b1;
        end else begin
            sb_q.push_back(model_mul(x, y));
            in_valid0 = 1'b1;
        end
        tick();
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        check({tag, "_in_ready_low"}, 32'(ee ? bus1.in_ready : bus0.in_ready), 32'd0);
        check({tag, "_busy"}, 32'(ee ? bus1.busy : bus0.busy), 32'd1);
        lat = 0;
        while (!dut_ov(ee) && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        sb_check(ee, {tag, "_out"}, ee ? bus1.out : bus0.out);
        tick();
        check({tag, "_idle"}, 32'(ee ? bus1.in_ready : bus0.in_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] x;
        logic [15:0] y;
        int          lat;
        logic        got;
        int          guard;

        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst_out", 32'(bus0.out), 32'd0);
        check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        check("rst_busy", 32'(bus0.busy), 32'd0);

        op(1'b0, 16'd3, 16'd5, 16, "mul_3x5");
        op(1'b0, 16'd300, 16'd300, 16, "mul_300x300");
        op(1'b0, 16'hFFFE, 16'd7, 16, "mul_m2x7");
        op(1'b0, 16'hFFFF, 16'hFFFF, 16, "mul_m1xm1");

        // Backpressure, with spurious in_valid pulses throughout RUN and DONE.
        a = 16'd12;
        b = 16'd10;
        sb_q.push_back(model_mul(16'd12, 16'd10));
        in_valid0 = 1'b1;
        out_ready = 1'b0;
        tick();
        a = 16'd1;
        b = 16'd1;
        lat = 0;
        while (!bus0.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd16);
        sb_check(1'b0, "bp_out", bus0.out);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(bus0.out_valid), 32'd1);
            check("bp_hold_out", 32'(bus0.out), 32'd120);
        end
        in_valid0 = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_idle", 32'(bus0.in_ready), 32'd1);
        check("bp_retained_out", 32'(bus0.out), 32'd120);
        check("bp_no_extra", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of RUN discards the operation.
        a = 16'd100;
        b = 16'd200;
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        #1;
        check("midrst_out", 32'(bus0.out), 32'd0);
        check("midrst_out_valid", 32'(bus0.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus0.in_ready), 32'd1);
        check("midrst_busy", 32'(bus0.busy), 32'd0);
        tick();
        reset = 1'b0;
        op(1'b0, 16'd2, 16'd2, 16, "post_reset");

        // Reset coinciding with an accept edge wins.
        a = 16'd5;
        b = 16'd5;
        in_valid0 = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid0 = 1'b0;
        #1;
        check("rst_vs_accept_idle", 32'(bus0.in_ready), 32'd1);
        check("rst_vs_accept_busy", 32'(bus0.busy), 32'd0);
        tick();
        check("rst_vs_accept_still_idle", 32'(bus0.busy), 32'd0);

        op(1'b1, 16'd9, 16'd1, 1, "ee_b1");
        op(1'b1, 16'd5, 16'd0, 0, "ee_b0");
        op(1'b1, 16'd1, 16'h8000, 16, "ee_msb");
        op(1'b1, 16'd7, 16'd6, 3, "ee_b6");

        // Random regression with random stalls and junk inputs while busy.
        for (int i = 0; i < 1000; i++) begin
            check("rand_ready", 32'(bus0.in_ready), 32'd1);
            x = 16'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            a = x;
            b = y;
            in_valid0 = 1'b1;
            sb_q.push_back(model_mul(x, y));
            tick();
            got = 1'b0;
            guard = 0;
            while (!got && guard < 100) begin
                a = 16'($urandom);
                b = 16'($urandom);
                in_valid0 = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                if (bus0.out_valid && out_ready) begin
                    sb_check(1'b0, "rand_out", bus0.out);
                    got = 1'b1;
                end
                tick();
                guard++;
            end
            in_valid0 = 1'b0;
            check("rand_completed", 32'(got), 32'd1);
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("ee_sb_drained", 32'(ee_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_mul16.md
Name: seq_mul16

Overview:
- Iterative shift-and-add 16-bit multiplier for the HACK datapath.
- Consumes the 16-bit adder's sum every cycle as its accumulator update. Adder has carry-out discarded, so result is the low 16 bits of the product.
- Sits between register-file/ALU operand sources and the writeback mux.
- Valid/ready handshake on both sides, so callers can stall it.

Parameters:
- WIDTH, 16, operand/result width; adder and all datapath registers are WIDTH bits.
- EARLY_EXIT, 0, when 1, finish as soon as the remaining multiplier bits are all zero.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  product mod 2^WIDTH.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Registers:
  - mcand (WIDTH): multiplicand, shifted left.
  - mplier (WIDTH): multiplier, shifted right.
  - acc (WIDTH): accumulator; drives out directly.
  - count (log2 WIDTH bits): iteration counter.
  - state: IDLE / RUN / DONE.
- Reset (asynchronous, any state): state=IDLE; acc, mcand, mplier, count = 0.
  - Outputs after reset: out=0, out_valid=0, in_ready=1, busy=0.
  - An in-flight operation is aborted and its result discarded.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: mcand<=a, mplier<=b, acc<=0, count<=0, state<=RUN.
  - If EARLY_EXIT=1 and b==0: state<=DONE directly, acc<=0.
- RUN, each edge:
  - acc<=acc+mcand if mplier[0]=1, else acc unchanged. Sum is WIDTH bits; carry-out dropped.
  - mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - Go to DONE when count==WIDTH-1, or when EARLY_EXIT=1 and (mplier>>1)==0.
- DONE:
  - out_valid=1; out=acc, held stable.
  - On an edge with out_ready=1: state<=IDLE. acc is retained, so out keeps the last result.
- Latency (EARLY_EXIT=0): accept on edge E0, out_valid rises after edge E16, i.e. 16 RUN cycles.
  - Throughput: one result per 18 cycles minimum (accept, 16 RUN, 1 DONE with out_ready=1).
- Handshake rules:
  - in_valid is ignored in RUN and DONE (in_ready=0). No back-to-back accept in the DONE→IDLE transition cycle.
  - out_ready is ignored outside DONE.
  - out is defined only while out_valid=1. It changes during RUN.
- Arithmetic:
  - Result equals (a*b) mod 2^WIDTH.
  - Identical for signed two's-complement and unsigned interpretation; no sign handling needed.
  - No overflow flag.
- Operands are sampled only at the accept edge; later changes on a/b have no effect.
- Stalls: out_ready held low keeps DONE indefinitely with out/out_valid stable.
- Reset asserted in the same cycle as the accept edge: reset wins; block stays IDLE.

Test Plan:
- Reset, then a=3, b=5, in_valid one cycle, out_ready=1 → in_ready drops next cycle; out_valid high exactly 16 cycles after accept with out=15; returns to IDLE next cycle.
- a=300, b=300 → out=24464 (90000 mod 65536). Then a=0xFFFE (−2), b=7 → out=0xFFF2 (−14). Then a=0xFFFF, b=0xFFFF → out=0x0001.
- Backpressure: a=12, b=10, out_ready=0 for 5 cycles after out_valid → out_valid and out=120 held stable all 5 cycles; in_valid pulses with a=1, b=1 during RUN and DONE are not accepted (result stays 120).
- Reset mid-operation: accept a=100, b=200, assert reset at RUN cycle 7 → out=0, out_valid=0, in_ready=1 immediately. A fresh a=2, b=2 then yields 4 with full 16-cycle latency.
- EARLY_EXIT=1: a=9, b=1 → out_valid after 1 RUN cycle, out=9. b=0 → DONE one edge after accept, out=0. b=0x8000, a=1 → full 16 cycles, out=0x8000.
- Random regression, 1000 operand pairs with random out_ready stalls → every out equals (a*b)&0xFFFF; no result lost or duplicated.
